// File: rtl/ptp_sp_ram.sv
// ptp_sp_ram: single-port RAM with per-byte write enables, a read latency of
// 1 or 2 cycles, a valid strobe on read data, and a clear engine that
// zero-fills the whole array after reset or on request.
//
// Optional feature macro: PTP_SP_RAM_RDW_BYPASS_EN
//   defined   : a read that collides with a write returns the new word,
//               merged per lane (enabled lanes from data, others stored).
//   undefined : a colliding read returns the old stored word.
//
// Ports:
//   clock    in   memory clock, rising edge
//   reset    in   asynchronous active-high reset
//   data     in   write data
//   address  in   word address shared by read and write
//   wren     in   write enable
//   byteena  in   per-lane write mask
//   rden     in   read enable
//   clear    in   single-cycle zero-fill request
//   q        out  read data, held until the next read completes
//   q_valid  out  one-cycle strobe marking new data on q
//   busy     out  clear sweep in progress; accesses ignored while high
module ptp_sp_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               data,
  input  logic [ADDR_WIDTH-1:0]               address,
  input  logic                                wren,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    byteena,
  input  logic                                rden,
  input  logic                                clear,
  output logic [DATA_WIDTH-1:0]               q,
  output logic                                q_valid,
  output logic                                busy
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("ptp_sp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("ptp_sp_ram: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Lane merge: enabled lanes take new_w, the rest keep old_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_w;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = old_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  state_t                state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_next_s;
  logic                  busy_r;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [NUM_BYTES-1:0]  mem_be_s;
  logic                  rd_accept_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Next-state logic: clear has priority over any access in IDLE; the
  // sweep writes one zero word per edge and leaves on the last address.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = address;
    mem_wdata_s  = data;
    mem_be_s     = byteena;
    rd_accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_next_s = ST_CLEAR;
          cnt_next_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          mem_we_s    = wren;
          rd_accept_s = rden;
        end
      end
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = cnt_r;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        mem_be_s    = {NUM_BYTES{1'b1}};
        if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          cnt_next_s = cnt_r + ADDR_WIDTH'(1'b1);
        end
      end
      default: begin
        state_next_s = ST_CLEAR;
        cnt_next_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // State, sweep counter and busy flag; reset starts a fresh sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == ST_CLEAR);
    end
  end

  // Storage array: no reset, contents are defined by the clear sweep.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= merge_lanes(mem_r[mem_addr_s], mem_wdata_s, mem_be_s);
    end
  end

  // Read word selection, including the read-during-write policy.
  always_comb begin
`ifdef PTP_SP_RAM_RDW_BYPASS_EN
    if (wren) begin
      rd_word_s = merge_lanes(mem_r[address], data, byteena);
    end else begin
      rd_word_s = mem_r[address];
    end
`else
    rd_word_s = mem_r[address];
`endif
  end

  // First read stage: data only updates on an accepted read so q holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] q_r;
      logic                  q_valid_r;

      // Output register stage for the two-cycle latency build.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          q_r       <= {DATA_WIDTH{1'b0}};
          q_valid_r <= 1'b0;
        end else begin
          q_valid_r <= rd_valid_r;
          if (rd_valid_r) begin
            q_r <= rd_data_r;
          end
        end
      end

      assign q       = q_r;
      assign q_valid = q_valid_r;
    end else begin : g_lat1
      assign q       = rd_data_r;
      assign q_valid = rd_valid_r;
    end
  endgenerate

  assign busy = busy_r;

endmodule

// File: tb/tb_ptp_sp_ram.sv
// tb_ptp_sp_ram: directed self-checking bench. Two instances share all
// inputs: dut1 with READ_LATENCY=1 and dut2 with READ_LATENCY=2.
// Expected collision data follows PTP_SP_RAM_RDW_BYPASS_EN.
module tb_ptp_sp_ram;

  logic        clock;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  address;
  logic        wren;
  logic [3:0]  byteena;
  logic        rden;
  logic        clear;
  logic [31:0] q1, q2;
  logic        v1, v2, b1, b2;

  int total;
  int bad;

  ptp_sp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BYTE_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .data(data), .address(address), .wren(wren),
    .byteena(byteena), .rden(rden), .clear(clear), .q(q1), .q_valid(v1), .busy(b1)
  );

  ptp_sp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BYTE_WIDTH(8), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .data(data), .address(address), .wren(wren),
    .byteena(byteena), .rden(rden), .clear(clear), .q(q2), .q_valid(v2), .busy(b2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single read on both instances; returns data and pulse counts.
  task automatic read_one(input logic [7:0] a, output logic [31:0] rq1, output logic [31:0] rq2,
                          output int p1, output int p2);
    p1 = 0;
    p2 = 0;
    address = a;
    rden = 1'b1;
    tick();
    rden = 1'b0;
    rq1 = q1;
    p1 += int'(v1);
    p2 += int'(v2);
    tick();
    rq2 = q2;
    p1 += int'(v1);
    p2 += int'(v2);
    tick();
    p1 += int'(v1);
    p2 += int'(v2);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a;
    data = d;
    byteena = be;
    wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({q1, v1, b1} !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state_lat1: got q=%h v=%b busy=%b want q=0 v=0 busy=1", q1, v1, b1);
    end
    total++;
    if ({q2, v2, b2} !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state_lat2: got q=%h v=%b busy=%b want q=0 v=0 busy=1", q2, v2, b2);
    end
    reset = 1'b0;
    edges = 0;
    while (b1 === 1'b1 && edges < 400) begin
      tick();
      edges++;
    end
    total++;
    if (edges !== 256) begin
      bad++;
      $display("FAIL reset_busy_edges: got %0d want 256", edges);
    end
    total++;
    if (b2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_lat2: got busy=%b want 0", b2);
    end
  endtask

  task automatic test_read_zero();
    logic [31:0] rq1, rq2;
    int p1, p2;
    logic [7:0] addrs [3];
    addrs = '{8'd0, 8'd127, 8'd255};
    for (int i = 0; i < 3; i++) begin
      read_one(addrs[i], rq1, rq2, p1, p2);
      total++;
      if ({rq1, rq2} !== {32'h0, 32'h0} || p1 !== 1 || p2 !== 1) begin
        bad++;
        $display("FAIL read_zero addr=%0d: got q1=%h q2=%h pulses=%0d/%0d want 0 0 1/1",
                 addrs[i], rq1, rq2, p1, p2);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rq1, rq2;
    int p1, p2;
    write_word(8'h10, 32'hAABBCCDD, 4'b1111);
    write_word(8'h10, 32'h11223344, 4'b0101);
    read_one(8'h10, rq1, rq2, p1, p2);
    total++;
    if (rq1 !== 32'hAA22CC44 || p1 !== 1) begin
      bad++;
      $display("FAIL byteena_lat1: got %h pulses=%0d want aa22cc44 1", rq1, p1);
    end
    total++;
    if (rq2 !== 32'hAA22CC44 || p2 !== 1) begin
      bad++;
      $display("FAIL byteena_lat2: got %h pulses=%0d want aa22cc44 1", rq2, p2);
    end
    total++;
    if (q1 !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL q_hold: got %h want aa22cc44", q1);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rq1, rq2, exp_c;
    int p1, p2;
`ifdef PTP_SP_RAM_RDW_BYPASS_EN
    exp_c = 32'h0000FFFF;
`else
    exp_c = 32'h00000000;
`endif
    address = 8'h20;
    data = 32'hFFFFFFFF;
    byteena = 4'b0011;
    wren = 1'b1;
    rden = 1'b1;
    tick();
    wren = 1'b0;
    rden = 1'b0;
    total++;
    if (q1 !== exp_c || v1 !== 1'b1) begin
      bad++;
      $display("FAIL collision_lat1: got %h v=%b want %h 1", q1, v1, exp_c);
    end
    tick();
    total++;
    if (q2 !== exp_c || v2 !== 1'b1) begin
      bad++;
      $display("FAIL collision_lat2: got %h v=%b want %h 1", q2, v2, exp_c);
    end
    read_one(8'h20, rq1, rq2, p1, p2);
    total++;
    if (rq1 !== 32'h0000FFFF || rq2 !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL collision_after: got %h %h want 0000ffff", rq1, rq2);
    end
  endtask

  task automatic test_clear();
    logic [31:0] rq1, rq2;
    int edges, vcount, zbad;
    for (int a = 0; a < 256; a++) begin
      write_word(a[7:0], 32'hA5000000 | 32'(a), 4'b1111);
    end
    // Read just before the clear request.
    address = 8'd5;
    rden = 1'b1;
    tick();
    rden = 1'b0;
    total++;
    if (q1 !== 32'hA5000005 || v1 !== 1'b1) begin
      bad++;
      $display("FAIL preclear_read_lat1: got %h v=%b want a5000005 1", q1, v1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (q2 !== 32'hA5000005 || v2 !== 1'b1 || b1 !== 1'b1) begin
      bad++;
      $display("FAIL preclear_read_lat2: got %h v=%b busy=%b want a5000005 1 1", q2, v2, b1);
    end
    // Hammer accesses for the whole sweep; none may land.
    address = 8'd7;
    data = 32'h12345678;
    byteena = 4'b1111;
    wren = 1'b1;
    rden = 1'b1;
    edges = 0;
    vcount = 0;
    while (b1 === 1'b1 && edges < 400) begin
      tick();
      edges++;
      vcount += int'(v1) + int'(v2);
    end
    wren = 1'b0;
    rden = 1'b0;
    total++;
    if (edges !== 256) begin
      bad++;
      $display("FAIL clear_busy_edges: got %0d want 256", edges);
    end
    total++;
    if (vcount !== 0) begin
      bad++;
      $display("FAIL clear_no_valid: got %0d pulses want 0", vcount);
    end
    // Back-to-back sweep of every address on the latency-1 instance.
    zbad = 0;
    for (int a = 0; a < 256; a++) begin
      address = a[7:0];
      rden = 1'b1;
      tick();
      if (q1 !== 32'h0 || v1 !== 1'b1) zbad++;
    end
    rden = 1'b0;
    total++;
    if (zbad !== 0) begin
      bad++;
      $display("FAIL clear_all_zero: got %0d nonzero reads want 0", zbad);
    end
    read_one(8'd7, rq1, rq2, edges, vcount);
    total++;
    if (rq2 !== 32'h0) begin
      bad++;
      $display("FAIL clear_ignored_write: got %h want 0", rq2);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] rq1, rq2;
    int p1, p2, edges;
    write_word(8'h10, 32'hDEADBEEF, 4'b1111);
    read_one(8'h10, rq1, rq2, p1, p2);
    total++;
    if (q1 !== 32'hDEADBEEF || q2 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL premidclear_q: got %h %h want deadbeef", q1, q2);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({q1, v1, b1, q2, v2, b2} !== {32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL midclear_reset: got q=%h/%h v=%b/%b busy=%b/%b want 0 0 1", q1, q2, v1, v2, b1, b2);
    end
    tick();
    tick();
    reset = 1'b0;
    edges = 0;
    while (b1 === 1'b1 && edges < 400) begin
      tick();
      edges++;
    end
    total++;
    if (edges !== 256) begin
      bad++;
      $display("FAIL midclear_busy_edges: got %0d want 256", edges);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, ebad;
    for (int i = 0; i < 16; i++) begin
      write_word(i[7:0], 32'h00000100 + 32'(i), 4'b1111);
    end
    pulses = 0;
    ebad = 0;
    for (int i = 0; i < 16; i++) begin
      address = i[7:0];
      rden = 1'b1;
      tick();
      pulses += int'(v2);
      if (q1 !== 32'h00000100 + 32'(i) || v1 !== 1'b1) ebad++;
      if (i == 0) begin
        if (v2 !== 1'b0) ebad++;
      end else begin
        if (q2 !== 32'h00000100 + 32'(i - 1) || v2 !== 1'b1) ebad++;
      end
    end
    rden = 1'b0;
    tick();
    pulses += int'(v2);
    if (q2 !== 32'h0000010F || v2 !== 1'b1) ebad++;
    tick();
    pulses += int'(v2);
    total++;
    if (ebad !== 0) begin
      bad++;
      $display("FAIL b2b_order: got %0d bad cycles want 0", ebad);
    end
    total++;
    if (pulses !== 16) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d want 16", pulses);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    data = 32'h0;
    address = 8'h0;
    wren = 1'b0;
    byteena = 4'h0;
    rden = 1'b0;
    clear = 1'b0;
    test_reset();
    test_read_zero();
    test_byte_enable();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
